// File: rtl/instr_loader_pkg.sv
// Shared types and default widths for the instruction-memory loader.
package loader_pkg;

  localparam int LDR_ADDR_W  = 3;
  localparam int LDR_INSTR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Writes switch words into consecutive instruction-memory slots on each load
// pulse, reads each word back to confirm it, and freezes on done or mismatch.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = LDR_ADDR_W,
  parameter int INSTR_W = LDR_INSTR_W,
  parameter int DEPTH   = 2**ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_pulse,
  input  logic               done_pulse,
  input  logic [INSTR_W-1:0] sw_instr,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [ADDR_W:0]    count,
  output logic               busy,
  output logic               full,
  output logic               err,
  output logic               load_done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  loader_state_t      r_state;
  logic [ADDR_W:0]    r_count;
  logic [INSTR_W-1:0] r_wbuf;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [ADDR_W-1:0]  r_raddr;
  logic               r_err;
  logic               r_done;
  logic               w_full;

  assign w_full = (r_count == DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_wbuf  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          // A load request always consumes a simultaneous done request.
          if (load_pulse) begin
            if (!w_full) begin
              r_wbuf  <= sw_instr;
              r_waddr <= r_count[ADDR_W-1:0];
              r_we    <= 1'b1;
              r_state <= WRITE;
            end
          end else if (done_pulse) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        WRITE: begin
          r_we    <= 1'b0;
          r_raddr <= r_count[ADDR_W-1:0];
          if (!w_full) begin
            r_count <= r_count + ONE_C;
          end
          r_state <= VERIFY;
        end
        VERIFY: begin
          if (mem_rdata == r_wbuf) begin
            r_state <= IDLE;
          end else begin
            r_err   <= 1'b1;
            r_state <= ERR;
          end
        end
        DONE: begin
          r_we <= 1'b0;
        end
        ERR: begin
          r_we <= 1'b0;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wbuf;
  assign mem_raddr = r_raddr;
  assign count     = r_count;
  assign full      = w_full;
  assign busy      = (r_state == WRITE) || (r_state == VERIFY);
  assign err       = r_err;
  assign load_done = r_done;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a small behavioural instruction memory.
module tb_instr_loader;

  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 12;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_pulse;
  logic               done_pulse;
  logic [INSTR_W-1:0] sw_instr;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [ADDR_W:0]    count;
  logic               busy;
  logic               full;
  logic               err;
  logic               load_done;

  logic [INSTR_W-1:0] mem [8] = '{default: 12'h000};
  logic               corrupt = 1'b0;
  int                 wr_cnt = 0;
  int                 errors = 0;
  int                 checks = 0;
  int                 wr_base;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_pulse (load_pulse),
    .done_pulse (done_pulse),
    .sw_instr   (sw_instr),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .count      (count),
    .busy       (busy),
    .full       (full),
    .err        (err),
    .load_done  (load_done)
  );

  // Memory model; optionally drops writes of all-ones to force a readback error.
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= (corrupt && mem_wdata == 12'hFFF) ? 12'h000 : mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    load_pulse = 1'b0;
    done_pulse = 1'b0;
    sw_instr   = '0;
    reset      = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [11:0] d, input int a);
    sw_instr   = d;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("we_k1", 32'(mem_we), 32'd1);
    chk("waddr_k1", 32'(mem_waddr), 32'(a));
    chk("wdata_k1", 32'(mem_wdata), 32'(d));
    tick();
    chk("count_k2", 32'(count), 32'(a + 1));
    chk("raddr_k2", 32'(mem_raddr), 32'(a));
    chk("busy_k2", 32'(busy), 32'd1);
    tick();
    chk("busy_k3", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values while reset is held low.
    load_pulse = 1'b0;
    done_pulse = 1'b0;
    sw_instr   = 12'hABC;
    reset      = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {28'd0, busy, full, err, load_done}, 32'd0);
    reset = 1'b1;
    tick();

    // Three loads at addresses 0..2.
    load_word(12'hA31, 0);
    load_word(12'h0F2, 1);
    load_word(12'h7C4, 2);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_mem1", 32'(mem[1]), 32'h0F2);

    // Fill all eight slots, then a ninth load is refused.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      load_word(12'(12'h100 + i), i);
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count8", 32'(count), 32'd8);
    wr_base = wr_cnt;
    sw_instr   = 12'h999;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("t2_no_we", 32'(mem_we), 32'd0);
    tick();
    tick();
    chk("t2_writes", 32'(wr_cnt - wr_base), 32'd0);
    chk("t2_count_hold", 32'(count), 32'd8);
    chk("t2_busy", 32'(busy), 32'd0);

    // Load pulse held across WRITE and VERIFY gives exactly one write.
    apply_reset();
    wr_base    = wr_cnt;
    sw_instr   = 12'h3C3;
    load_pulse = 1'b1;
    tick();
    tick();
    tick();
    load_pulse = 1'b0;
    tick();
    tick();
    chk("t3_writes", 32'(wr_cnt - wr_base), 32'd1);
    chk("t3_count", 32'(count), 32'd1);

    // Corrupted readback drives the loader into its error state.
    apply_reset();
    corrupt    = 1'b1;
    sw_instr   = 12'hFFF;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("t4_we", 32'(mem_we), 32'd1);
    tick();
    chk("t4_err_k2", 32'(err), 32'd0);
    tick();
    chk("t4_err_k3", 32'(err), 32'd1);
    corrupt    = 1'b0;
    wr_base    = wr_cnt;
    sw_instr   = 12'h123;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("t4_no_we", 32'(mem_we), 32'd0);
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    tick();
    chk("t4_writes", 32'(wr_cnt - wr_base), 32'd0);
    chk("t4_no_done", 32'(load_done), 32'd0);
    chk("t4_err_sticky", 32'(err), 32'd1);

    // Two loads, then done freezes the program.
    apply_reset();
    load_word(12'h555, 0);
    load_word(12'h2AA, 1);
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    chk("t5_done", 32'(load_done), 32'd1);
    wr_base    = wr_cnt;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("t5_no_we", 32'(mem_we), 32'd0);
    tick();
    tick();
    chk("t5_writes", 32'(wr_cnt - wr_base), 32'd0);
    chk("t5_count", 32'(count), 32'd2);

    // Simultaneous load and done: the load wins, done is lost.
    apply_reset();
    sw_instr   = 12'h6E1;
    load_pulse = 1'b1;
    done_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    done_pulse = 1'b0;
    chk("t6_we", 32'(mem_we), 32'd1);
    chk("t6_done_k1", 32'(load_done), 32'd0);
    tick();
    tick();
    tick();
    chk("t6_done_late", 32'(load_done), 32'd0);
    chk("t6_count", 32'(count), 32'd1);

    // Reset asserted in the middle of a WRITE cycle clears outputs at once.
    apply_reset();
    load_word(12'h5A5, 0);
    sw_instr   = 12'hC3D;
    load_pulse = 1'b1;
    tick();
    load_pulse = 1'b0;
    chk("t7_we_pre", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t7_we", 32'(mem_we), 32'd0);
    chk("t7_waddr", 32'(mem_waddr), 32'd0);
    chk("t7_wdata", 32'(mem_wdata), 32'd0);
    chk("t7_count", 32'(count), 32'd0);
    chk("t7_flags", {28'd0, busy, full, err, load_done}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Write-side companion of the instruction memory. Takes 12-bit instructions from the board switches and writes them into consecutive instruction-memory addresses on each debounced button pulse. After each write it reads the word back through the memory's read port and compares it with what was written. It sits between the `debouncer` outputs and the instruction memory's write port, and hands a filled program to `PC` and the controller once `load_done` asserts.

## Interface
Parameters:
- `ADDR_W`, 3, instruction-memory address width
- `INSTR_W`, 12, instruction width
- `DEPTH`, 2**`ADDR_W` (8), number of loadable words

Ports:
- `clk` in 1: system clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-low; all state cleared while low
- `load_pulse` in 1: single-cycle debounced "store switch word" request
- `done_pulse` in 1: single-cycle debounced "program complete" request
- `sw_instr` in `INSTR_W`: instruction value on the switches
- `mem_we` out 1: instruction-memory write enable
- `mem_waddr` out `ADDR_W`: write address
- `mem_wdata` out `INSTR_W`: write data
- `mem_raddr` out `ADDR_W`: readback address
- `mem_rdata` in `INSTR_W`: combinational read data for `mem_raddr`
- `count` out `ADDR_W`+1: number of words written, 0..`DEPTH`
- `busy` out 1: write/verify in progress
- `full` out 1: `count` == `DEPTH`
- `err` out 1: sticky readback mismatch
- `load_done` out 1: program frozen, ready for execution

## Operation
- States: IDLE, WRITE, VERIFY, DONE, ERR.
- IDLE:
  - On `load_pulse` with !`full`: latch `sw_instr` into `wbuf` and go to WRITE.
  - On `load_pulse` with `full`: ignored; stay in IDLE.
  - Otherwise on `done_pulse`: go to DONE.
  - If `load_pulse` and `done_pulse` arrive in the same cycle, load wins and the done request is dropped. The user must press again.
- WRITE (one cycle):
  - `mem_we`=1, `mem_waddr`=`count`[`ADDR_W`-1:0], `mem_wdata`=`wbuf`.
  - At the end of the cycle, `count`+=1 and the state moves to VERIFY.
- VERIFY (one cycle):
  - `mem_raddr`=`count`-1.
  - If `mem_rdata`==`wbuf`, go to IDLE; otherwise go to ERR.
- DONE: `load_done`=1 and all pulses are ignored. Only `reset` leaves this state.
- ERR: `err`=1 and all pulses are ignored. Only `reset` leaves this state.
- `busy` = (state is WRITE or VERIFY). Any `load_pulse` or `done_pulse` that arrives while busy is dropped.
- `count` saturates at `DEPTH`. `full` is derived combinationally from `count`.
- `mem_waddr` never wraps, because writes are blocked when `full`. The address after the last word (`count`=8) is never driven on `mem_waddr`.
- When not in VERIFY, `mem_raddr` holds its last value. `mem_wdata` always reflects `wbuf`.

## Timing
- Reset values: `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `mem_raddr`=0, `count`=0, `busy`=0, `full`=0, `err`=0, `load_done`=0, state=IDLE, `wbuf`=0.
- `reset` taking effect mid-WRITE deasserts `mem_we` immediately, without waiting for a clock edge.
- Pulse accepted in cycle k → `mem_we` high in cycle k+1 → VERIFY in cycle k+2 → IDLE in cycle k+3.
- Sustained throughput is one word per 3 cycles.
- `count` is visible updated from cycle k+2.
- `done_pulse` accepted in cycle k → `load_done`=1 from cycle k+1.
- Mismatch detected in cycle k+2 → `err`=1 from cycle k+3.
- Everything is registered except `full` and `busy`, which decode registered state.

## Structure
- Package `loader_pkg`:
  - `loader_state_t` enum (IDLE, WRITE, VERIFY, DONE, ERR)
  - defaults for `INSTR_W`/`ADDR_W`
- No sub-module.
  - One FSM with `count`/`wbuf` registers in a single module.
  - Debouncing stays in the existing `debouncer` instances outside the block.

## Test plan
- Reset, then 3 loads of `sw_instr` = 12'hA31, 12'h0F2, 12'h7C4 → writes at addresses 0, 1, 2 with matching data; `count`=3, `err`=0.
- 9 loads → 8 writes (addresses 0..7), `full`=1 after the 8th, 9th pulse produces no `mem_we`, `count` stays 8.
- `load_pulse` held during WRITE/VERIFY (cycles k+1, k+2) → exactly one write.
- Memory model returns 12'h000 for a write of 12'hFFF → `err`=1 at k+3; later pulses produce no `mem_we`.
- 2 loads, then `done_pulse` → `load_done`=1 next cycle; a further `load_pulse` produces no write.
- Simultaneous `load_pulse`+`done_pulse` in IDLE → one write occurs and `load_done` stays 0.
- `reset` asserted mid-WRITE → all outputs return to reset values without a clock edge.
